gpi_debounce_ctrl: RTL and testbench

- Conditions the raw board switch/button inputs before they reach the demo system general-purpose input port.
- Per bit, it synchronises the input, debounces it on a shared prescaled sample tick, and emits rise/fall pulses.
- It latches edge events into write-1-to-clear pending bits and drives one aggregated interrupt line.
- It sits between the board IO pins and the demo system GPI/IRQ inputs in the FPGA top level.

---
 rtl/gpi_debounce_ctrl.sv | 151 +++++++++++++++
 tb/tb_gpi_debounce_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpi_debounce_ctrl.sv
// Conditions raw board switch/button inputs for the GPI port. Each bit is
// synchronised, debounced on a shared prescaled sample tick, and produces
// rise/fall pulses that latch into write-1-to-clear pending bits feeding one
// aggregated interrupt line.
//
// Ports:
//   clk_sys_i   system clock
//   rst_sys_ni  asynchronous active-low reset
//   gp_raw_i    raw asynchronous pin levels
//   gp_o        debounced stable levels
//   rise_o      one-cycle pulse per bit on an accepted 0->1 change
//   fall_o      one-cycle pulse per bit on an accepted 1->0 change
//   irq_en_i    per-bit enable for setting the pending bit
//   clear_i     per-bit write-1-to-clear strobe for pending_o
//   pending_o   latched edge events
//   irq_o       OR-reduction of pending_o
module gpi_debounce_ctrl #(
    parameter int unsigned Width       = 8,
    parameter int unsigned SyncStages  = 2,
    parameter int unsigned TickDiv     = 1000,
    parameter int unsigned StableTicks = 20
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_ni,
    input  logic [Width-1:0] gp_raw_i,
    output logic [Width-1:0] gp_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o,
    input  logic [Width-1:0] irq_en_i,
    input  logic [Width-1:0] clear_i,
    output logic [Width-1:0] pending_o,
    output logic             irq_o
);

    localparam int unsigned PW = (TickDiv > 1) ? $clog2(TickDiv) : 1;
    localparam int unsigned CW = $clog2(StableTicks + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TickDiv - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(StableTicks - 1);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CAND   = 1'b1
    } state_e;

    logic [Width-1:0] sync_q [SyncStages];
    logic [Width-1:0] sync_d [SyncStages];
    logic [Width-1:0] sync_c;

    logic [PW-1:0]    presc_q, presc_d;
    logic             tick_c;

    state_e           state_q [Width];
    state_e           state_d [Width];
    logic [CW-1:0]    cnt_q   [Width];
    logic [CW-1:0]    cnt_d   [Width];

    logic [Width-1:0] gp_q, gp_d;
    logic [Width-1:0] rise_q, rise_d;
    logic [Width-1:0] fall_q, fall_d;
    logic [Width-1:0] pending_q, pending_d;

    // Input synchroniser chain; the last stage is the only one consumed.
    always_comb begin
        sync_d[0] = gp_raw_i;
        for (int k = 1; k < SyncStages; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    assign sync_c = sync_q[SyncStages-1];

    // Free-running sample prescaler; tick marks the terminal count.
    always_comb begin
        tick_c  = (presc_q == PRESC_MAX);
        presc_d = tick_c ? '0 : presc_q + PW'(1);
    end

    // Per-bit STABLE/CANDIDATE debounce; a matching sample aborts a candidate.
    always_comb begin
        logic [CW-1:0] cnt_eff;
        cnt_eff = '0;
        gp_d    = gp_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < Width; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (tick_c) begin
                if (sync_c[i] == gp_q[i]) begin
                    cnt_d[i]   = '0;
                    state_d[i] = ST_STABLE;
                end else begin
                    cnt_eff = (state_q[i] == ST_CAND) ? cnt_q[i] : '0;
                    if (cnt_eff >= CNT_LAST) begin
                        gp_d[i]    = sync_c[i];
                        rise_d[i]  = sync_c[i];
                        fall_d[i]  = ~sync_c[i];
                        cnt_d[i]   = '0;
                        state_d[i] = ST_STABLE;
                    end else begin
                        cnt_d[i]   = cnt_eff + CW'(1);
                        state_d[i] = ST_CAND;
                    end
                end
            end
        end
    end

    // Pending bits: a new enabled edge takes priority over a same-cycle clear.
    always_comb begin
        pending_d = (pending_q & ~clear_i) | ((rise_q | fall_q) & irq_en_i);
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            for (int k = 0; k < SyncStages; k++) begin
                sync_q[k] <= '0;
            end
            presc_q <= '0;
            for (int i = 0; i < Width; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
            gp_q      <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            pending_q <= '0;
        end else begin
            for (int k = 0; k < SyncStages; k++) begin
                sync_q[k] <= sync_d[k];
            end
            presc_q <= presc_d;
            for (int i = 0; i < Width; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            gp_q      <= gp_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            pending_q <= pending_d;
        end
    end

    assign gp_o      = gp_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign pending_o = pending_q;
    // Pure OR of registered bits so the line tracks pending_o in the same cycle.
    assign irq_o     = |pending_q;

endmodule

// File: tb/tb_gpi_debounce_ctrl.sv
// Directed bench for gpi_debounce_ctrl with TickDiv=4, StableTicks=3,
// SyncStages=2. Inputs are driven and outputs sampled on the falling edge.
module tb_gpi_debounce_ctrl;

    localparam int unsigned W = 8;

    logic         clk_sys_i = 1'b0;
    logic         rst_sys_ni;
    logic [W-1:0] gp_raw_i;
    logic [W-1:0] gp_o;
    logic [W-1:0] rise_o;
    logic [W-1:0] fall_o;
    logic [W-1:0] irq_en_i;
    logic [W-1:0] clear_i;
    logic [W-1:0] pending_o;
    logic         irq_o;

    int n_tests = 0;
    int n_fail  = 0;

    gpi_debounce_ctrl #(
        .Width      (W),
        .SyncStages (2),
        .TickDiv    (4),
        .StableTicks(3)
    ) dut (
        .clk_sys_i (clk_sys_i),
        .rst_sys_ni(rst_sys_ni),
        .gp_raw_i  (gp_raw_i),
        .gp_o      (gp_o),
        .rise_o    (rise_o),
        .fall_o    (fall_o),
        .irq_en_i  (irq_en_i),
        .clear_i   (clear_i),
        .pending_o (pending_o),
        .irq_o     (irq_o)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        logic [4*W-1:0] acc;
        logic           irq_acc;
        rst_sys_ni = 1'b0;
        gp_raw_i   = '0;
        irq_en_i   = '0;
        clear_i    = '0;
        repeat (3) @(negedge clk_sys_i);
        n_tests++;
        if ({gp_o, rise_o, fall_o, pending_o, irq_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_held: outputs=%h required 0", {gp_o, rise_o, fall_o, pending_o, irq_o});
        end
        rst_sys_ni = 1'b1;
        acc     = '0;
        irq_acc = 1'b0;
        repeat (200) begin
            @(negedge clk_sys_i);
            acc     = acc | {gp_o, rise_o, fall_o, pending_o};
            irq_acc = irq_acc | irq_o;
        end
        n_tests++;
        if (acc !== '0) begin
            n_fail++;
            $display("FAIL idle_outputs: or-of-outputs=%h required 0", acc);
        end
        n_tests++;
        if (irq_acc !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_irq: irq seen=%b required 0", irq_acc);
        end
    endtask

    task automatic test_rise();
        int lat;
        lat      = 0;
        irq_en_i = 8'hFF;
        gp_raw_i = 8'h01;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk_sys_i);
            if (gp_o[0] === 1'b1) begin
                lat = n;
                break;
            end
        end
        n_tests++;
        if (lat < 11 || lat > 14) begin
            n_fail++;
            $display("FAIL rise_latency: latency=%0d required 11..14", lat);
        end
        n_tests++;
        if (rise_o !== 8'h01 || fall_o !== 8'h00 || pending_o !== 8'h00) begin
            n_fail++;
            $display("FAIL rise_pulse: rise=%h fall=%h pend=%h required 01 00 00", rise_o, fall_o, pending_o);
        end
        @(negedge clk_sys_i);
        n_tests++;
        if (rise_o !== 8'h00 || gp_o !== 8'h01) begin
            n_fail++;
            $display("FAIL rise_one_cycle: rise=%h gp=%h required 00 01", rise_o, gp_o);
        end
        n_tests++;
        if (pending_o !== 8'h01 || irq_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rise_pending: pend=%h irq=%b required 01 1", pending_o, irq_o);
        end
    endtask

    task automatic test_bounce();
        logic [W-1:0] edges;
        logic         gp3;
        edges    = '0;
        gp3      = 1'b0;
        gp_raw_i = 8'h09;
        repeat (6) begin
            @(negedge clk_sys_i);
            edges = edges | rise_o | fall_o;
            gp3   = gp3 | gp_o[3];
        end
        gp_raw_i = 8'h01;
        repeat (40) begin
            @(negedge clk_sys_i);
            edges = edges | rise_o | fall_o;
            gp3   = gp3 | gp_o[3];
        end
        n_tests++;
        if (gp3 !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_gp: gp3 seen=%b required 0", gp3);
        end
        n_tests++;
        if (edges !== 8'h00) begin
            n_fail++;
            $display("FAIL bounce_edges: edges=%h required 00", edges);
        end
        n_tests++;
        if (pending_o !== 8'h01 || gp_o !== 8'h01) begin
            n_fail++;
            $display("FAIL bounce_state: pend=%h gp=%h required 01 01", pending_o, gp_o);
        end
    endtask

    task automatic test_clear();
        int lat;
        clear_i = 8'h01;
        @(negedge clk_sys_i);
        clear_i = 8'h00;
        n_tests++;
        if (pending_o !== 8'h00 || irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL clear: pend=%h irq=%b required 00 0", pending_o, irq_o);
        end
        lat      = 0;
        gp_raw_i = 8'h00;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk_sys_i);
            if (fall_o[0] === 1'b1) begin
                lat = n;
                break;
            end
        end
        clear_i = 8'h01;
        n_tests++;
        if (lat < 11 || lat > 14 || gp_o !== 8'h00) begin
            n_fail++;
            $display("FAIL fall_latency: latency=%0d gp=%h required 11..14 00", lat, gp_o);
        end
        @(negedge clk_sys_i);
        clear_i = 8'h00;
        n_tests++;
        if (pending_o !== 8'h01 || irq_o !== 1'b1 || fall_o !== 8'h00) begin
            n_fail++;
            $display("FAIL set_wins: pend=%h irq=%b fall=%h required 01 1 00", pending_o, irq_o, fall_o);
        end
        clear_i = 8'h01;
        @(negedge clk_sys_i);
        clear_i = 8'h00;
        n_tests++;
        if (pending_o !== 8'h00) begin
            n_fail++;
            $display("FAIL reclear: pend=%h required 00", pending_o);
        end
    endtask

    task automatic test_multi();
        int lat;
        lat      = 0;
        irq_en_i = 8'h30;
        gp_raw_i = 8'hF0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk_sys_i);
            if (rise_o !== 8'h00) begin
                lat = n;
                break;
            end
        end
        n_tests++;
        if (rise_o !== 8'hF0 || lat < 11 || lat > 14) begin
            n_fail++;
            $display("FAIL multi_rise: rise=%h latency=%0d required F0 11..14", rise_o, lat);
        end
        @(negedge clk_sys_i);
        n_tests++;
        if (pending_o !== 8'h30 || irq_o !== 1'b1 || gp_o !== 8'hF0 || rise_o !== 8'h00) begin
            n_fail++;
            $display("FAIL multi_pending: pend=%h irq=%b gp=%h rise=%h required 30 1 F0 00",
                     pending_o, irq_o, gp_o, rise_o);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        gp_raw_i = 8'hF4;
        // Ten cycles after the step bit 2 has seen exactly two differing ticks.
        repeat (10) @(negedge clk_sys_i);
        n_tests++;
        if (gp_o !== 8'hF0) begin
            n_fail++;
            $display("FAIL mid_candidate: gp=%h required F0", gp_o);
        end
        rst_sys_ni = 1'b0;
        #1;
        n_tests++;
        if ({gp_o, rise_o, fall_o, pending_o, irq_o} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: outputs=%h required 0", {gp_o, rise_o, fall_o, pending_o, irq_o});
        end
        @(negedge clk_sys_i);
        rst_sys_ni = 1'b1;
        lat = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk_sys_i);
            if (gp_o !== 8'h00) begin
                lat = n;
                break;
            end
        end
        n_tests++;
        if (lat != 12) begin
            n_fail++;
            $display("FAIL post_reset_latency: latency=%0d required 12", lat);
        end
        n_tests++;
        if (gp_o !== 8'hF4 || rise_o !== 8'hF4) begin
            n_fail++;
            $display("FAIL post_reset_rise: gp=%h rise=%h required F4 F4", gp_o, rise_o);
        end
        @(negedge clk_sys_i);
        n_tests++;
        if (pending_o !== 8'h30 || irq_o !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_pending: pend=%h irq=%b required 30 1", pending_o, irq_o);
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_bounce();
        test_clear();
        test_multi();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
